// File: rtl/hdmi_i2c_target_regfile.sv
// hdmi_i2c_target_regfile: oversampled I2C target fronting a 2**AW x 8 register file with a fabric read port
module hdmi_i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h39,
    parameter int          AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [AW-1:0] host_addr,
    output logic [7:0]    host_rdata,
    output logic          busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE
    } state_t;

    state_t        state, state_n;
    logic [1:0]    scl_s, sda_s;
    logic          scl_p, sda_p, scl, sda, scl_rise, scl_fall, start, stop;
    logic [7:0]    mem [2**AW];
    logic [7:0]    shift, shift_n, byte_in;
    logic [3:0]    bcnt, bcnt_n;
    logic [AW-1:0] ptr, ptr_n, ptr_inc;
    logic          rw, rw_n, sda_oe_n, busy_n, commit;

    assign scl      = scl_s[1];
    assign sda      = sda_s[1];
    assign scl_rise = scl & ~scl_p;
    assign scl_fall = ~scl & scl_p;
    assign start    = scl & scl_p & sda_p & ~sda;
    assign stop     = scl & scl_p & ~sda_p & sda;
    assign byte_in  = {shift[6:0], sda};
    assign ptr_inc  = ptr + 1'b1;

    // Pin synchronizers and edge history; kept out of reset so a reset mid-transfer cannot fabricate a START
    always_ff @(posedge clk) begin
        scl_s <= {scl_s[0], scl_in};
        sda_s <= {sda_s[0], sda_in};
        scl_p <= scl_s[1];
        sda_p <= sda_s[1];
    end

    // Protocol next-state: bus conditions override bit handling; SDA drive only moves on SCL falls
    always_comb begin
        state_n  = state;
        shift_n  = shift;
        bcnt_n   = bcnt;
        ptr_n    = ptr;
        rw_n     = rw;
        sda_oe_n = sda_oe;
        busy_n   = busy;
        commit   = 1'b0;
        if (start) begin
            state_n  = ADDR;
            bcnt_n   = 4'd0;
            sda_oe_n = 1'b0;
            busy_n   = 1'b1;
        end else if (stop) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            case (state)
                ADDR, REG, WDATA: if (scl_rise) begin
                    shift_n = byte_in;
                    bcnt_n  = bcnt + 4'd1;
                    if (bcnt == 4'd7) begin
                        bcnt_n = 4'd0;
                        if (state == ADDR) begin
                            state_n = (byte_in[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                            busy_n  = byte_in[7:1] == DEV_ADDR;
                            rw_n    = byte_in[0];
                        end else if (state == REG) begin
                            state_n = REG_ACK;
                            ptr_n   = AW'(byte_in);
                        end else begin
                            state_n = WDATA_ACK;
                            commit  = 1'b1;
                            ptr_n   = ptr_inc;
                        end
                    end
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                    sda_oe_n = ~sda_oe;
                    if (sda_oe) begin
                        bcnt_n  = 4'd0;
                        state_n = (state == ADDR_ACK) ? (rw ? RDATA : REG) : WDATA;
                        if (state == ADDR_ACK && rw) begin
                            shift_n  = mem[ptr];
                            sda_oe_n = ~mem[ptr][7];
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) bcnt_n = bcnt + 4'd1;
                    else if (scl_fall) begin
                        sda_oe_n = bcnt[3] ? 1'b0 : ~shift[~bcnt[2:0]];
                        state_n  = bcnt[3] ? RDATA_MACK : RDATA;
                    end
                end
                RDATA_MACK: if (scl_rise) begin
                    state_n = sda ? IGNORE : RDATA;
                    if (!sda) begin
                        ptr_n   = ptr_inc;
                        shift_n = mem[ptr_inc];
                        bcnt_n  = 4'd0;
                    end
                end
                IDLE, IGNORE: state_n = state;
                default: state_n = IDLE;
            endcase
        end
    end

    // State and output registers, plus the registered host read
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= 8'h00;
            bcnt       <= 4'd0;
            ptr        <= '0;
            rw         <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            host_rdata <= 8'h00;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bcnt       <= bcnt_n;
            ptr        <= ptr_n;
            rw         <= rw_n;
            sda_oe     <= sda_oe_n;
            busy       <= busy_n;
            wr_en      <= commit;
            if (commit) begin
                wr_addr <= ptr;
                wr_data <= byte_in;
            end
            host_rdata <= mem[host_addr];
        end
    end

    // Register file write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (commit && !reset) mem[ptr] <= byte_in;
    end
endmodule

// File: tb/tb_hdmi_i2c_target_regfile.sv
// tb_hdmi_i2c_target_regfile: bit-banged I2C master with write/read scoreboards
module tb_hdmi_i2c_target_regfile;
    localparam int Q = 50;

    logic       clk = 1'b0, reset = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
    logic       sda_oe, wr_en, busy, sda_line;
    logic [7:0] wr_addr, wr_data, host_rdata, host_addr = 8'h00;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [15:0] e;
    int n_chk = 0, n_pass = 0, oe_cnt = 0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    hdmi_i2c_target_regfile dut (
        .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .host_addr(host_addr), .host_rdata(host_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Write scoreboard: every wr_en pulse must match the oldest expected write
    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (wr_en) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", 32'(wr_en), 32'd0);
            else begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[15:8]));
                chk("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
    end

    task automatic start_c;
        sda_m = 1'b1; #Q scl_m = 1'b1; #Q sda_m = 1'b0; #Q scl_m = 1'b0; #Q;
    endtask

    task automatic stop_c;
        sda_m = 1'b0; #Q scl_m = 1'b1; #Q sda_m = 1'b1; #(2*Q);
    endtask

    task automatic bit_c(input logic b);
        sda_m = b; #Q scl_m = 1'b1; #(2*Q) scl_m = 1'b0; #Q;
    endtask

    task automatic ack_slot(output logic a);
        sda_m = 1'b1; #Q scl_m = 1'b1; #Q a = sda_line; #Q scl_m = 1'b0; #Q;
    endtask

    task automatic byte_c(input logic [7:0] b, input string tag, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) bit_c(b[i]);
        ack_slot(a);
        chk(tag, 32'(a), 32'(exp_ack));
    endtask

    task automatic read_c(input logic mack, input string tag);
        logic [7:0] d;
        logic [7:0] x;
        d = 8'h00;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #Q scl_m = 1'b1; #Q d = {d[6:0], sda_line}; #Q scl_m = 1'b0; #Q;
        end
        x = exp_rd.pop_front();
        chk(tag, 32'(d), 32'(x));
        sda_m = mack; #Q scl_m = 1'b1; #Q chk({tag, "_mack_rel"}, 32'(sda_oe), 32'd0);
        #Q scl_m = 1'b0; #Q sda_m = 1'b1;
    endtask

    task automatic host_chk(input logic [7:0] a, input logic [7:0] x, input string tag);
        host_addr = a;
        @(negedge clk); @(negedge clk);
        chk(tag, 32'(host_rdata), 32'(x));
    endtask

    task automatic write_c(input logic [7:0] r, input logic [7:0] d, input string tag);
        exp_wr.push_back({r, d});
        start_c;
        byte_c(8'h72, {tag, "_ack_dev"}, 1'b0);
        byte_c(r, {tag, "_ack_reg"}, 1'b0);
        byte_c(d, {tag, "_ack_dat"}, 1'b0);
        stop_c;
    endtask

    initial begin
        logic a;
        int snap;
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        reset = 1'b0;
        #(4*Q);

        exp_wr.push_back(16'h9803);
        start_c;
        chk("w1_busy_start", 32'(busy), 32'd1);
        byte_c(8'h72, "w1_ack_dev", 1'b0);
        byte_c(8'h98, "w1_ack_reg", 1'b0);
        byte_c(8'h03, "w1_ack_dat", 1'b0);
        stop_c;
        chk("w1_busy_stop", 32'(busy), 32'd0);
        host_chk(8'h98, 8'h03, "w1_host");

        write_c(8'h10, 8'hC3, "pre10");
        snap = oe_cnt;
        start_c;
        byte_c(8'h74, "wa_nack_dev", 1'b1);
        chk("wa_busy_drop", 32'(busy), 32'd0);
        byte_c(8'h10, "wa_nack_reg", 1'b1);
        byte_c(8'h55, "wa_nack_dat", 1'b1);
        stop_c;
        chk("wa_oe_quiet", 32'(oe_cnt - snap), 32'd0);
        host_chk(8'h10, 8'hC3, "wa_host_unchanged");

        exp_wr.push_back(16'hFE11);
        exp_wr.push_back(16'hFF22);
        exp_wr.push_back(16'h0033);
        start_c;
        byte_c(8'h72, "bw_ack_dev", 1'b0);
        byte_c(8'hFE, "bw_ack_reg", 1'b0);
        byte_c(8'h11, "bw_ack_d0", 1'b0);
        byte_c(8'h22, "bw_ack_d1", 1'b0);
        byte_c(8'h33, "bw_ack_d2", 1'b0);
        stop_c;
        host_chk(8'hFF, 8'h22, "bw_host_ff");
        host_chk(8'h00, 8'h33, "bw_host_00");

        exp_wr.push_back(16'h9D61);
        exp_wr.push_back(16'h9EA4);
        start_c;
        byte_c(8'h72, "pr_ack_dev", 1'b0);
        byte_c(8'h9D, "pr_ack_reg", 1'b0);
        byte_c(8'h61, "pr_ack_d0", 1'b0);
        byte_c(8'hA4, "pr_ack_d1", 1'b0);
        stop_c;
        start_c;
        byte_c(8'h72, "rd_ack_dev", 1'b0);
        byte_c(8'h9D, "rd_ack_reg", 1'b0);
        start_c;
        byte_c(8'h73, "rd_ack_rdev", 1'b0);
        exp_rd.push_back(8'h61);
        read_c(1'b0, "rd_b0");
        exp_rd.push_back(8'hA4);
        read_c(1'b1, "rd_b1");
        chk("rd_nack_rel", 32'(sda_oe), 32'd0);
        #(2*Q);
        chk("rd_nack_rel2", 32'(sda_oe), 32'd0);
        stop_c;
        chk("rd_busy_stop", 32'(busy), 32'd0);

        start_c;
        byte_c(8'h72, "ab_ack_dev", 1'b0);
        byte_c(8'h30, "ab_ack_reg", 1'b0);
        bit_c(1'b1); bit_c(1'b0); bit_c(1'b1); bit_c(1'b0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("ab_sda_oe", 32'(sda_oe), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        bit_c(1'b1); bit_c(1'b1); bit_c(1'b0); bit_c(1'b0);
        ack_slot(a);
        chk("ab_ignored_ack", 32'(a), 32'd1);
        stop_c;
        write_c(8'h41, 8'h10, "ab_rec");
        host_chk(8'h41, 8'h10, "ab_host");

        exp_wr.push_back(16'h215A);
        start_c;
        byte_c(8'h72, "rs_ack_dev", 1'b0);
        byte_c(8'h20, "rs_ack_reg", 1'b0);
        bit_c(1'b0); bit_c(1'b1); bit_c(1'b0); bit_c(1'b1);
        start_c;
        byte_c(8'h72, "rs_ack_dev2", 1'b0);
        byte_c(8'h21, "rs_ack_reg2", 1'b0);
        byte_c(8'h5A, "rs_ack_dat", 1'b0);
        stop_c;
        host_chk(8'h21, 8'h5A, "rs_host");

        #(4*Q);
        chk("wr_left", 32'(exp_wr.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hdmi_i2c_target_regfile.md
Name: hdmi_i2c_target_regfile

Overview:
- I2C target (responder) holding a 256 x 8 register file, addressed as the 7-bit device HDMI transmitter configuration traffic uses (write byte 0x72, read byte 0x73).
- Serves as the far end of the HDMI I2C configuration bus: a synthesizable transmitter register model for closed-loop simulation, or an FPGA-side slave on a shared bus.
- Oversamples SCL/SDA with the system clock and drives SDA open-drain.
- Exposes a write-strobe and a host read port so fabric logic can observe the programmed configuration.

Parameters:
- DEV_ADDR, 7'h39, 7-bit target address (0x72 >> 1).
- AW, 8, register address width; the file holds 2**AW bytes.

Ports:
- clk  in  1  system clock; must be at least 16x the SCL frequency.
- reset  in  1  synchronous, active-high.
- scl_in  in  1  SCL pin sample (asynchronous).
- sda_in  in  1  SDA pin sample (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- wr_en  out  1  one-cycle pulse when a data byte is committed.
- wr_addr  out  AW  register written.
- wr_data  out  8  byte written.
- host_addr  in  AW  fabric-side read address.
- host_rdata  out  8  reg[host_addr], registered, 1-cycle latency.
- busy  out  1  high from START until STOP or address mismatch.

Behaviour:
- **Synchronizers:** scl_in and sda_in pass through 2-FF synchronizers plus a previous-value register. Edges are detected on the synchronized values.
  - scl_rise / scl_fall: SCL transitions.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bus timing:** SDA is sampled on scl_rise. sda_oe changes only on the clk after scl_fall, never while SCL is high.
- **Reset:** state=IDLE, sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, pointer=0, bit count=0, host_rdata=0. Register file contents are not reset.
- **States:** IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE.
- **Priority:** START in any state -> ADDR, bit count=0, sda_oe=0, busy=1. This covers repeated start. STOP in any state -> IDLE, sda_oe=0, busy=0. START/STOP take priority over bit processing in the same cycle.
- **ADDR:** shift 8 bits MSB first.
  - On the 8th bit with addr[7:1]==DEV_ADDR -> ADDR_ACK, drive sda_oe=1 for the ACK clock. Release on the following scl_fall.
  - R/W=0 -> REG. R/W=1 -> load shift register with reg[pointer], then RDATA.
  - Mismatch -> IGNORE: no ACK, busy=0, stay until START/STOP.
- **REG:** 8 bits -> pointer. ACK -> WDATA.
- **WDATA:** on the 8th bit, the cycle after that scl_rise:
  - wr_en=1, wr_addr=pointer, wr_data=byte, reg[pointer]=byte.
  - ACK, pointer += 1 modulo 2**AW (0xFF wraps to 0x00).
  - Loop to WDATA for burst writes.
- **RDATA:** drive sda_oe = ~shift[7] after each scl_fall, MSB first, 8 bits. After the 8th bit release SDA and go to RDATA_MACK.
- **RDATA_MACK:** sample SDA on scl_rise.
  - 0 (master ACK): pointer += 1, reload shift register from the new pointer, RDATA.
  - 1 (NACK): IGNORE until STOP/START, SDA released.
- **Pointer:** the pointer persists across transactions, so a write of only the register address followed by a repeated-start read returns reg[pointer].
- **Host port:** host_rdata <= reg[host_addr] every clk. A same-cycle I2C write and host read of one address returns the old data.
- **Mid-operation reset:** returns to IDLE immediately, SDA released. The next byte on the bus is ignored until a fresh START.
- **wr_en:** never asserted for address bytes, register-address bytes, or read transactions.

Test Plan:
- **Single write:** START, 0x72, 0x98, 0x03, STOP.
  - sda_oe low on all 3 ACK slots.
  - Exactly one wr_en with wr_addr=0x98, wr_data=0x03.
  - host_addr=0x98 -> host_rdata=0x03.
- **Wrong address:** START, 0x74, 0x10, 0x55, STOP.
  - sda_oe stays 0 throughout, no wr_en, busy drops after byte 1.
  - reg[0x10] unchanged.
- **Burst with wrap:** START, 0x72, 0xFE, 0x11, 0x22, 0x33, STOP.
  - wr_en three times at addresses 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33.
- **Random read:** preload reg[0x9D]=0x61, reg[0x9E]=0xA4. Send START, 0x72, 0x9D, Sr, 0x73, then master ACK, NACK, STOP.
  - SDA bits read 0x61 then 0xA4.
  - sda_oe released during master ACK/NACK slots and after the NACK.
- **Abort and recovery:** assert reset for 1 clk after the 4th data bit of a write.
  - No wr_en, sda_oe=0.
  - Remaining bits ignored.
  - A following complete write of 0x72, 0x41, 0x10 succeeds.
- **Repeated start mid-write:** START, 0x72, 0x20, 4 bits, START, 0x72, 0x21, 0x5A, STOP.
  - Only one wr_en, at addr=0x21 with data 0x5A.
